gate_resp_checker: RTL and testbench
====================================

GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

Interface
REQ-001 Parameter NUM_IMPL, default 3, is the number of gate implementations whose outputs are checked in parallel.
REQ-002 Parameter CNT_W, default 8, is the width of the vector and mismatch counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; clears results and begins a check session.
REQ-006 in_valid  input  1  a response sample is present.
REQ-007 in_ready  output  1  the checker accepts a sample this cycle.
REQ-008 in_a, in_b  input  1 each  stimulus bits applied to the gates.
REQ-009 in_y  input  NUM_IMPL  one output bit per implementation.
REQ-010 in_last  input  1  marks the final sample of the session.
REQ-011 done  output  1  the session is complete and results are stable.
REQ-012 pass  output  1  valid while done is high; high when the session met the pass conditions in REQ-021.
REQ-013 vec_cnt  output  CNT_W  number of accepted samples.
REQ-014 err_cnt  output  CNT_W  number of accepted samples with at least one mismatching implementation.
REQ-015 cov  output  4  truth-table coverage bitmap; bit index is {a,b}.
REQ-016 fail_info  output  2+NUM_IMPL  first failing sample, captured as {a, b, y}.
REQ-017 fail_mask  output  NUM_IMPL  OR of the per-implementation mismatch bits over the session.

Function
REQ-018 The FSM has three states:
- IDLE: start moves to RUN.
- RUN: a handshake with in_last high moves to DONE.
- DONE: start moves to RUN.
- Otherwise the FSM holds its state.
REQ-019 in_ready is high only in RUN; a sample is accepted only when in_valid and in_ready are both high.
REQ-020 On each accepted sample:
- expected = ~(in_a | in_b);
- per-implementation mismatch = in_y[i] XOR expected;
- cov bit {in_a,in_b} is set;
- vec_cnt increments;
- err_cnt increments if any mismatch bit is set;
- fail_mask accumulates the mismatch bits.
REQ-021 pass = (err_cnt == 0) AND (cov == 4'hF) AND (no counter saturated).
REQ-022 vec_cnt and err_cnt saturate at all-ones; a saturated counter holds its value.
REQ-023 fail_info is captured only on the first mismatching sample of a session; later mismatches do not change it.
REQ-024 done is registered and goes high in the cycle after the in_last handshake; the counters include that last sample.
REQ-025 When start enters RUN from IDLE or DONE, it clears done, pass, the counters, cov, fail_info and fail_mask in the same edge.
REQ-026 In the cycle after a start pulse, in_ready is high; a sample presented in the start cycle is not accepted.
REQ-027 start while in RUN restarts the session: all results are cleared, the state stays RUN, and any sample handshaking in that same cycle is discarded.
REQ-028 in_last with in_valid low has no effect.
REQ-029 Results hold unchanged in IDLE and in DONE.

Reset
REQ-030 When rst_n is low, the following are forced asynchronously:
- state = IDLE;
- in_ready = 0, done = 0, pass = 0;
- vec_cnt = 0, err_cnt = 0;
- cov = 0, fail_info = 0, fail_mask = 0.
REQ-031 Reset asserted during RUN aborts the session; no partial result is reported.
REQ-032 After rst_n deasserts, the block waits in IDLE for start.

Structure
REQ-033 The shared package gate_chk_pkg holds the state encodings (IDLE, RUN, DONE), the full-coverage constant 4'hF and the expected-NOR function.
REQ-034 One sub-module, sat_counter (CNT_W wide, with clear and increment inputs), is instantiated twice: once for vec_cnt and once for err_cnt.
REQ-035 All outputs are driven from registers.

Verification
REQ-036 Exhaustive good run: start, then the samples (0,0,y=111), (0,1,000), (1,0,000), (1,1,000 with last) -> done one cycle after the last sample, pass=1, vec_cnt=4, err_cnt=0, cov=F.
REQ-037 Single faulty implementation: the same run but (1,0) sends y=010 -> err_cnt=1, fail_mask=010, fail_info={1,0,010}, pass=0.
REQ-038 Coverage hole: samples (0,0) and (1,1) only, all correct, with last -> pass=0, cov=1001, err_cnt=0.
REQ-039 Backpressure and idle: in_valid held high in IDLE and in DONE -> in_ready=0 and the counters do not change.
REQ-040 Saturation: with CNT_W=2, five mismatching samples -> err_cnt=3 and pass=0.
REQ-041 Mid-run events:
- rst_n low after 2 samples -> all outputs 0 immediately and state IDLE;
- start pulse after 2 samples -> counters read 0 in the next cycle.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker.
// Holds the session FSM encoding, the full-coverage constant and the
// reference model of the gate under test (2-input NOR).
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Every row of the 2-input truth table has been exercised.
    localparam logic [3:0] COV_FULL = 4'hF;

    // Reference output every implementation is compared against.
    function automatic logic exp_nor(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk/rst_n (async active-low), clr_i (priority over inc_i), inc_i,
//        cnt_o (registered count), cnt_nxt_o (value the count takes at the next edge).
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_nxt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/gate_resp_checker.sv
// Checks NUM_IMPL parallel NOR-gate implementations against a reference over a
// session of valid/ready samples and reports counts, coverage and first failure.
// Ports: clk, rst_n (async active-low), start, in_valid/in_ready handshake,
//        in_a/in_b/in_y/in_last sample, done/pass/vec_cnt/err_cnt/cov/fail_info/fail_mask results.
// Latency: done rises in the cycle after the in_last handshake; in_ready is high only in RUN.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int NUM_IMPL = 3,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_a,
    input  logic                  in_b,
    input  logic [NUM_IMPL-1:0]   in_y,
    input  logic                  in_last,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      vec_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [3:0]            cov,
    output logic [NUM_IMPL+1:0]   fail_info,
    output logic [NUM_IMPL-1:0]   fail_mask
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [3:0]            cov_q, cov_d;
    logic [NUM_IMPL+1:0]   fail_info_q, fail_info_d;
    logic [NUM_IMPL-1:0]   fail_mask_q, fail_mask_d;

    logic                  acc;
    logic                  exp_y;
    logic [NUM_IMPL-1:0]   mis;
    logic                  any_mis;
    logic [CNT_W-1:0]      vec_nxt;
    logic [CNT_W-1:0]      err_nxt;

    // A start pulse takes priority: any sample handshaking in the same cycle
    // belongs to the abandoned session and is dropped.
    assign acc     = in_valid && ready_q && !start;
    assign exp_y   = exp_nor(in_a, in_b);
    assign mis     = in_y ^ {NUM_IMPL{exp_y}};
    assign any_mis = |mis;

    sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (start),
        .inc_i     (acc),
        .cnt_o     (vec_cnt),
        .cnt_nxt_o (vec_nxt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (start),
        .inc_i     (acc && any_mis),
        .cnt_o     (err_cnt),
        .cnt_nxt_o (err_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (acc && in_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / result next-state logic
    always_comb begin
        ready_d     = (state_d == ST_RUN);
        done_d      = done_q;
        pass_d      = pass_q;
        cov_d       = cov_q;
        fail_info_d = fail_info_q;
        fail_mask_d = fail_mask_q;
        if (start) begin
            done_d      = 1'b0;
            pass_d      = 1'b0;
            cov_d       = '0;
            fail_info_d = '0;
            fail_mask_d = '0;
        end else if (acc) begin
            cov_d       = cov_q | (4'b0001 << {in_a, in_b});
            fail_mask_d = fail_mask_q | mis;
            // An all-zero mask means no mismatch has been seen this session yet.
            if (any_mis && (fail_mask_q == '0)) begin
                fail_info_d = {in_a, in_b, in_y};
            end
            if (in_last) begin
                done_d = 1'b1;
                // Judged on the post-sample values so the last sample counts.
                pass_d = (err_nxt == '0) && (cov_d == COV_FULL) &&
                         (vec_nxt != CNT_MAX) && (err_nxt != CNT_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cov_q       <= '0;
            fail_info_q <= '0;
            fail_mask_q <= '0;
        end else begin
            ready_q     <= ready_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            cov_q       <= cov_d;
            fail_info_q <= fail_info_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign in_ready  = ready_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign cov       = cov_q;
    assign fail_info = fail_info_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker: a default instance (CNT_W=8) and a
// CNT_W=2 instance share the stimulus; expected values are hand-computed.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_gate_resp_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_a;
    logic       in_b;
    logic [2:0] in_y;
    logic       in_last;

    logic       in_ready, done, pass;
    logic [7:0] vec_cnt, err_cnt;
    logic [3:0] cov;
    logic [4:0] fail_info;
    logic [2:0] fail_mask;

    logic       s_ready, s_done, s_pass;
    logic [1:0] s_vec, s_err;
    logic [3:0] s_cov;
    logic [4:0] s_fail_info;
    logic [2:0] s_fail_mask;

    int n_checks;
    int n_fail;

    gate_resp_checker #(.NUM_IMPL(3), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .in_last(in_last), .done(done), .pass(pass), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .cov(cov), .fail_info(fail_info), .fail_mask(fail_mask)
    );

    gate_resp_checker #(.NUM_IMPL(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(s_ready), .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .in_last(in_last), .done(s_done), .pass(s_pass), .vec_cnt(s_vec),
        .err_cnt(s_err), .cov(s_cov), .fail_info(s_fail_info), .fail_mask(s_fail_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic a, input logic b, input logic [2:0] y, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_y     = y;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  {31'd0, in_ready}, 32'd0);
        check({tag, "_done"},   {31'd0, done},     32'd0);
        check({tag, "_pass"},   {31'd0, pass},     32'd0);
        check({tag, "_vec"},    {24'd0, vec_cnt},  32'd0);
        check({tag, "_err"},    {24'd0, err_cnt},  32'd0);
        check({tag, "_cov"},    {28'd0, cov},      32'd0);
        check({tag, "_finfo"},  {27'd0, fail_info}, 32'd0);
        check({tag, "_fmask"},  {29'd0, fail_mask}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_a     = 1'b0;
        in_b     = 1'b0;
        in_y     = 3'b000;
        in_last  = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        check("reset_s_ready", {31'd0, s_ready}, 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Exhaustive good run
        pulse_start();
        check("good_ready_after_start", {31'd0, in_ready}, 32'd1);
        send(1'b0, 1'b0, 3'b111, 1'b0);
        send(1'b0, 1'b1, 3'b000, 1'b0);
        send(1'b1, 1'b0, 3'b000, 1'b0);
        check("good_vec_mid", {24'd0, vec_cnt}, 32'd3);
        check("good_done_mid", {31'd0, done}, 32'd0);
        send(1'b1, 1'b1, 3'b000, 1'b1);
        check("good_done", {31'd0, done}, 32'd1);
        check("good_pass", {31'd0, pass}, 32'd1);
        check("good_vec", {24'd0, vec_cnt}, 32'd4);
        check("good_err", {24'd0, err_cnt}, 32'd0);
        check("good_cov", {28'd0, cov}, 32'hF);
        check("good_fmask", {29'd0, fail_mask}, 32'd0);
        check("good_ready_done", {31'd0, in_ready}, 32'd0);

        // Single faulty implementation; a mismatching sample offered during
        // the start cycle must not be accepted.
        in_valid = 1'b1; in_a = 1'b0; in_b = 1'b0; in_y = 3'b000;
        pulse_start();
        in_valid = 1'b0;
        check("fault_start_sample_dropped", {24'd0, vec_cnt}, 32'd0);
        check("fault_cleared_done", {31'd0, done}, 32'd0);
        send(1'b0, 1'b0, 3'b111, 1'b0);
        send(1'b0, 1'b1, 3'b000, 1'b0);
        send(1'b1, 1'b0, 3'b010, 1'b0);
        send(1'b1, 1'b1, 3'b000, 1'b1);
        check("fault_done", {31'd0, done}, 32'd1);
        check("fault_pass", {31'd0, pass}, 32'd0);
        check("fault_vec", {24'd0, vec_cnt}, 32'd4);
        check("fault_err", {24'd0, err_cnt}, 32'd1);
        check("fault_fmask", {29'd0, fail_mask}, 32'b010);
        check("fault_finfo", {27'd0, fail_info}, 32'b10010);
        check("fault_cov", {28'd0, cov}, 32'hF);

        // Coverage hole
        pulse_start();
        send(1'b0, 1'b0, 3'b111, 1'b0);
        send(1'b1, 1'b1, 3'b000, 1'b1);
        check("hole_done", {31'd0, done}, 32'd1);
        check("hole_pass", {31'd0, pass}, 32'd0);
        check("hole_cov", {28'd0, cov}, 32'b1001);
        check("hole_err", {24'd0, err_cnt}, 32'd0);
        check("hole_vec", {24'd0, vec_cnt}, 32'd2);

        // Backpressure in DONE
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b0; in_y = 3'b111; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_bp_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("done_bp_vec", {24'd0, vec_cnt}, 32'd2);
        check("done_bp_err", {24'd0, err_cnt}, 32'd0);
        check("done_bp_done", {31'd0, done}, 32'd1);

        // in_last without in_valid, then saturation on the CNT_W=2 instance
        pulse_start();
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        check("last_novalid_done", {31'd0, done}, 32'd0);
        check("last_novalid_vec", {24'd0, vec_cnt}, 32'd0);
        check("sat_ready", {31'd0, s_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 1'b0, 3'b000, (i == 4));
        end
        check("sat_done", {31'd0, s_done}, 32'd1);
        check("sat_err", {30'd0, s_err}, 32'd3);
        check("sat_vec", {30'd0, s_vec}, 32'd3);
        check("sat_pass", {31'd0, s_pass}, 32'd0);
        check("sat_cov", {28'd0, s_cov}, 32'b0001);
        check("sat_fmask", {29'd0, s_fail_mask}, 32'b111);
        check("sat_finfo", {27'd0, s_fail_info}, 32'd0);
        check("wide_err", {24'd0, err_cnt}, 32'd5);

        // Mid-run restart: the sample in the start cycle is discarded
        pulse_start();
        send(1'b0, 1'b1, 3'b000, 1'b0);
        send(1'b0, 1'b0, 3'b000, 1'b0);
        check("restart_pre_vec", {24'd0, vec_cnt}, 32'd2);
        check("restart_pre_err", {24'd0, err_cnt}, 32'd1);
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; in_y = 3'b111; in_last = 1'b1;
        pulse_start();
        in_valid = 1'b0; in_last = 1'b0;
        check("restart_vec", {24'd0, vec_cnt}, 32'd0);
        check("restart_err", {24'd0, err_cnt}, 32'd0);
        check("restart_cov", {28'd0, cov}, 32'd0);
        check("restart_fmask", {29'd0, fail_mask}, 32'd0);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_ready", {31'd0, in_ready}, 32'd1);

        // Mid-run reset
        send(1'b1, 1'b1, 3'b000, 1'b0);
        send(1'b1, 1'b0, 3'b111, 1'b0);
        check("prereset_fmask", {29'd0, fail_mask}, 32'b111);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle backpressure after reset
        in_valid = 1'b1; in_a = 1'b0; in_b = 1'b0; in_y = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_bp_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("idle_bp_vec", {24'd0, vec_cnt}, 32'd0);
        check("idle_bp_done", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
